// File: rtl/stopwatch_bcd.sv
// Start/stop/clear stopwatch counting whole seconds as three BCD digits, saturating at MAX_SECONDS.
// Latency: control edges act one cycle after the input rises, all outputs registered; no backpressure.
module stopwatch_bcd #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_SECONDS   = 999
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    output logic [3:0] Ones,
    output logic [3:0] Tens,
    output logic [3:0] Hundreds,
    output logic       Running,
    output logic       Full,
    output logic       SecTick
);

    localparam int            PW    = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] TERM  = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    MAX_O = 4'(MAX_SECONDS % 10);
    localparam logic [3:0]    MAX_T = 4'((MAX_SECONDS / 10) % 10);
    localparam logic [3:0]    MAX_H = 4'(MAX_SECONDS / 100);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, FULL} state_t;

    state_t        state_q, state_d;
    logic          start_q, stop_q, clear_q;
    logic          start_edge, stop_edge, clear_edge;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d, hund_q, hund_d;
    logic          running_q, running_d, full_q, full_d, tick_q, tick_d;

    assign start_edge = Start & ~start_q;
    assign stop_edge  = Stop  & ~stop_q;
    assign clear_edge = Clear & ~clear_q;

    // Edge registers reset high so a level held through reset never looks like a fresh press.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            start_q   <= 1'b1;
            stop_q    <= 1'b1;
            clear_q   <= 1'b1;
            presc_q   <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hund_q    <= 4'd0;
            running_q <= 1'b0;
            full_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= Start;
            stop_q    <= Stop;
            clear_q   <= Clear;
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hund_q    <= hund_d;
            running_q <= running_d;
            full_q    <= full_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        tick_d  = 1'b0;
        if (clear_edge) begin
            state_d = IDLE;
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            hund_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_edge) state_d = RUN;
                end
                RUN: begin
                    if (presc_q == TERM) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            if (tens_q == 4'd9) begin
                                tens_d = 4'd0;
                                hund_d = hund_q + 4'd1;
                            end else begin
                                tens_d = tens_q + 4'd1;
                            end
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // Saturation wins over a coincident Stop; a Stop on the terminal cycle keeps its second.
                    if (ones_d == MAX_O && tens_d == MAX_T && hund_d == MAX_H) state_d = FULL;
                    else if (stop_edge)                                       state_d = PAUSED;
                end
                PAUSED: begin
                    if (start_edge) state_d = RUN;
                end
                FULL: begin
                    presc_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == RUN);
        full_d    = (state_d == FULL);
    end

    assign Ones     = ones_q;
    assign Tens     = tens_q;
    assign Hundreds = hund_q;
    assign Running  = running_q;
    assign Full     = full_q;
    assign SecTick  = tick_q;

endmodule
